// File: rtl/pipe_scroller.sv
// Pipe obstacle sequencer: keeps five scrolling pipe slots, recycles the leftmost
// one to the tail, latches gap edges from the external height ROM, and keeps score/difficulty.
module pipe_scroller #(
    parameter int SCREEN_W        = 640,
    parameter int PIPE_W          = 40,
    parameter int SPACING         = 128,
    parameter int SPEED           = 2,
    parameter int PIPES_PER_LEVEL = 8,
    parameter int MAX_CLA         = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        frame_tick,
    input  logic        halt,
    output logic [2:0]  rom_idx,
    output logic [3:0]  rom_cla,
    input  logic [9:0]  yedge_t0,
    input  logic [9:0]  yedge_t1,
    input  logic [9:0]  yedge_t2,
    input  logic [9:0]  yedge_t3,
    input  logic [9:0]  yedge_t4,
    input  logic [9:0]  yedge_b0,
    input  logic [9:0]  yedge_b1,
    input  logic [9:0]  yedge_b2,
    input  logic [9:0]  yedge_b3,
    input  logic [9:0]  yedge_b4,
    output logic [10:0] pipe_xr0,
    output logic [10:0] pipe_xr1,
    output logic [10:0] pipe_xr2,
    output logic [10:0] pipe_xr3,
    output logic [10:0] pipe_xr4,
    output logic [9:0]  pipe_top0,
    output logic [9:0]  pipe_top1,
    output logic [9:0]  pipe_top2,
    output logic [9:0]  pipe_top3,
    output logic [9:0]  pipe_top4,
    output logic [9:0]  pipe_bot0,
    output logic [9:0]  pipe_bot1,
    output logic [9:0]  pipe_bot2,
    output logic [9:0]  pipe_bot3,
    output logic [9:0]  pipe_bot4,
    output logic [7:0]  score,
    output logic        running,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_RUN     = 3'd3,
        S_ADVANCE = 3'd4,
        S_STOPPED = 3'd5
    } state_t;

    localparam int              PASS_W    = (PIPES_PER_LEVEL > 2) ? $clog2(PIPES_PER_LEVEL) : 1;
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PIPES_PER_LEVEL - 1);
    localparam logic [10:0]     SPEED_W   = 11'(SPEED);
    localparam logic [10:0]     SPACING_W = 11'(SPACING);
    localparam logic [3:0]      MAX_CLA_W = 4'(MAX_CLA);

    state_t              state_q, state_d;
    logic [2:0]          head_q, head_d;
    logic [2:0]          idx_q, idx_d;
    logic [3:0]          cla_q, cla_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [7:0]          score_q, score_d;
    logic                pend_q, pend_d;
    logic [10:0]         xr_q [5];
    logic [10:0]         xr_d [5];
    logic [9:0]          top_q [5];
    logic [9:0]          top_d [5];
    logic [9:0]          bot_q [5];
    logic [9:0]          bot_d [5];

    logic [9:0]          yt [5];
    logic [9:0]          yb [5];
    logic [2:0]          tail;

    assign yt[0] = yedge_t0;
    assign yt[1] = yedge_t1;
    assign yt[2] = yedge_t2;
    assign yt[3] = yedge_t3;
    assign yt[4] = yedge_t4;
    assign yb[0] = yedge_b0;
    assign yb[1] = yedge_b1;
    assign yb[2] = yedge_b2;
    assign yb[3] = yedge_b3;
    assign yb[4] = yedge_b4;

    function automatic logic [2:0] inc5(input logic [2:0] v);
        return (v >= 3'd4) ? 3'd0 : v + 3'd1;
    endfunction

    function automatic logic [2:0] dec5(input logic [2:0] v);
        return (v == 3'd0) ? 3'd4 : v - 3'd1;
    endfunction

    // The slot behind the head is the tail in RUN, and the just-recycled slot in ADVANCE.
    assign tail = dec5(head_q);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        idx_d   = idx_q;
        cla_d   = cla_q;
        pass_d  = pass_q;
        score_d = score_q;
        pend_d  = pend_q;
        xr_d    = xr_q;
        top_d   = top_q;
        bot_d   = bot_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                idx_d   = 3'd0;
                cla_d   = 4'd0;
                pass_d  = '0;
                score_d = 8'd0;
                head_d  = 3'd0;
                pend_d  = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    xr_d[k] = 11'(SCREEN_W + PIPE_W + k * SPACING);
                end
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                for (int k = 0; k < 5; k++) begin
                    top_d[k] = yt[k];
                    bot_d[k] = yb[k];
                end
                state_d = S_RUN;
            end
            S_RUN: begin
                if (halt) begin
                    pend_d  = 1'b0;
                    state_d = S_STOPPED;
                end else if (frame_tick || pend_q) begin
                    pend_d = 1'b0;
                    for (int k = 0; k < 5; k++) begin
                        xr_d[k] = xr_q[k] - SPEED_W;
                    end
                    if (xr_q[head_q] <= SPEED_W) begin
                        // Re-enter one spacing behind the tail's post-scroll position.
                        xr_d[head_q] = xr_q[tail] - SPEED_W + SPACING_W;
                        head_d       = inc5(head_q);
                        idx_d        = inc5(idx_q);
                        score_d      = score_q + 8'd1;
                        if (pass_q == PASS_LAST) begin
                            pass_d = '0;
                            if (cla_q < MAX_CLA_W) cla_d = cla_q + 4'd1;
                        end else begin
                            pass_d = pass_q + 1'b1;
                        end
                        state_d = S_ADVANCE;
                    end
                end
            end
            S_ADVANCE: begin
                top_d[tail] = yt[4];
                bot_d[tail] = yb[4];
                if (halt) begin
                    pend_d  = 1'b0;
                    state_d = S_STOPPED;
                end else begin
                    if (frame_tick) pend_d = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_STOPPED: begin
                if (start) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            head_q  <= 3'd0;
            idx_q   <= 3'd0;
            cla_q   <= 4'd0;
            pass_q  <= '0;
            score_q <= 8'd0;
            pend_q  <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                xr_q[k]  <= 11'd0;
                top_q[k] <= 10'd0;
                bot_q[k] <= 10'd0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            idx_q   <= idx_d;
            cla_q   <= cla_d;
            pass_q  <= pass_d;
            score_q <= score_d;
            pend_q  <= pend_d;
            for (int k = 0; k < 5; k++) begin
                xr_q[k]  <= xr_d[k];
                top_q[k] <= top_d[k];
                bot_q[k] <= bot_d[k];
            end
        end
    end

    assign rom_idx   = idx_q;
    assign rom_cla   = cla_q;
    assign score     = score_q;
    assign running   = (state_q == S_RUN) || (state_q == S_ADVANCE);
    assign state_o   = state_q;

    assign pipe_xr0  = xr_q[0];
    assign pipe_xr1  = xr_q[1];
    assign pipe_xr2  = xr_q[2];
    assign pipe_xr3  = xr_q[3];
    assign pipe_xr4  = xr_q[4];
    assign pipe_top0 = top_q[0];
    assign pipe_top1 = top_q[1];
    assign pipe_top2 = top_q[2];
    assign pipe_top3 = top_q[3];
    assign pipe_top4 = top_q[4];
    assign pipe_bot0 = bot_q[0];
    assign pipe_bot1 = bot_q[1];
    assign pipe_bot2 = bot_q[2];
    assign pipe_bot3 = bot_q[3];
    assign pipe_bot4 = bot_q[4];

endmodule
